// File: rtl/bus_arbiter3.sv
// Round-robin arbiter/sequencer for the shared 3-input bus mux; registers the selected word onto bus_out.
// Latency: grant one edge after a request is seen in IDLE; bus word captured each owned edge.
// Backpressure: hold limit preempts a long owner when others wait; 1-cycle GAP between owners.
module bus_arbiter3 #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    output logic [2:0]       gnt,
    output logic [1:0]       set,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    state_t             r_state;
    logic [2:0]         r_gnt;
    logic [1:0]         r_set;
    logic [WIDTH-1:0]   r_bus_out;
    logic               r_bus_valid;
    logic               r_busy;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [1:0]         r_last_owner;

    state_t             w_next_state;
    logic [2:0]         w_next_gnt;
    logic [1:0]         w_next_set;
    logic               w_next_valid;
    logic [CNT_W-1:0]   w_next_hold;
    logic [1:0]         w_next_last;
    logic               w_capture;
    logic [1:0]         w_winner;
    logic [2:0]         w_winner_oh;
    logic [WIDTH-1:0]   w_mux_dat;
    logic               w_owner_req;
    logic               w_others_req;
    logic               w_timeout;

    // The owner is identified by its grant bit, so no out-of-range select can index req.
    assign w_owner_req  = |(req & r_gnt);
    assign w_others_req = |(req & ~r_gnt);
    assign w_timeout    = (r_hold_cnt == HOLD_LIMIT) && w_others_req;
    assign w_winner_oh  = 3'(3'b001 << w_winner);

    // Round-robin pick: scan starting just after the last owner.
    always_comb begin
        w_winner = 2'd0;
        case (r_last_owner)
            2'd0: begin
                if (req[1])      w_winner = 2'd1;
                else if (req[2]) w_winner = 2'd2;
                else             w_winner = 2'd0;
            end
            2'd1: begin
                if (req[2])      w_winner = 2'd2;
                else if (req[0]) w_winner = 2'd0;
                else             w_winner = 2'd1;
            end
            default: begin
                if (req[0])      w_winner = 2'd0;
                else if (req[1]) w_winner = 2'd1;
                else             w_winner = 2'd2;
            end
        endcase
    end

    // Bus mux driven by the registered select; select 3 cannot occur.
    always_comb begin
        w_mux_dat = din2;
        case (r_set)
            2'd0:    w_mux_dat = din0;
            2'd1:    w_mux_dat = din1;
            default: w_mux_dat = din2;
        endcase
    end

    // Next-state and next-output decode for the IDLE/GRANT/GAP sequencer.
    always_comb begin
        w_next_state = r_state;
        w_next_gnt   = 3'b000;
        w_next_set   = r_set;
        w_next_valid = 1'b0;
        w_next_hold  = r_hold_cnt;
        w_next_last  = r_last_owner;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req != 3'b000) begin
                    w_next_state = S_GRANT;
                    w_next_gnt   = w_winner_oh;
                    w_next_set   = w_winner;
                    w_next_hold  = CNT_W'(1);
                end
            end
            S_GRANT: begin
                // Release and timeout share one exit path; the exit edge captures nothing.
                if (!w_owner_req || w_timeout) begin
                    w_next_state = S_GAP;
                    w_next_last  = r_set;
                    w_next_hold  = '0;
                end else begin
                    w_next_gnt   = r_gnt;
                    w_next_valid = 1'b1;
                    w_capture    = 1'b1;
                    if (r_hold_cnt != HOLD_LIMIT)
                        w_next_hold = r_hold_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, grant, select and hold bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gnt        <= 3'b000;
            r_set        <= 2'd0;
            r_bus_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_hold_cnt   <= '0;
            r_last_owner <= 2'd2;
        end else begin
            r_state      <= w_next_state;
            r_gnt        <= w_next_gnt;
            r_set        <= w_next_set;
            r_bus_valid  <= w_next_valid;
            r_busy       <= (w_next_state != S_IDLE);
            r_hold_cnt   <= w_next_hold;
            r_last_owner <= w_next_last;
        end
    end

    // Bus word register: loads only on owned edges, otherwise holds its last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bus_out <= '0;
        else if (w_capture)
            r_bus_out <= w_mux_dat;
    end

    assign gnt       = r_gnt;
    assign set       = r_set;
    assign bus_out   = r_bus_out;
    assign bus_valid = r_bus_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bus_arbiter3.sv
// Directed bench for bus_arbiter3: reset, single owner, reset mid-grant, round robin,
// preemption, lone hold and release-on-timeout, plus an unsampled request glitch.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_bus_arbiter3;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [15:0] din0;
    logic [15:0] din1;
    logic [15:0] din2;
    logic [2:0]  gnt;
    logic [1:0]  set;
    logic [15:0] bus_out;
    logic        bus_valid;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    bus_arbiter3 #(.WIDTH(16), .MAX_HOLD(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .gnt       (gnt),
        .set       (set),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] oh;
        logic [1:0] ow;

        rst_n = 1'b0; req = 3'b000; din0 = '0; din1 = '0; din2 = '0;
        #3;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_set", set, 2'd0);
        chk("rst_bus", bus_out, 16'h0000);
        chk("rst_valid", bus_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tick(); tick();
        rst_n = 1'b1;

        // Single requester 1 for five sampled edges -> four captured words
        req = 3'b010; din1 = 16'hBEEF;
        tick();
        chk("single_gnt", gnt, 3'b010);
        chk("single_set", set, 2'd1);
        chk("single_busy", busy, 1'b1);
        chk("single_valid0", bus_valid, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("single_valid", bus_valid, 1'b1);
            chk("single_bus", bus_out, 16'hBEEF);
            chk("single_gnt_hold", gnt, 3'b010);
        end
        req = 3'b000;
        tick();
        chk("single_exit_gnt", gnt, 3'b000);
        chk("single_exit_valid", bus_valid, 1'b0);
        chk("single_exit_bus", bus_out, 16'hBEEF);
        chk("single_gap_busy", busy, 1'b1);
        tick();
        chk("single_idle_busy", busy, 1'b0);
        chk("single_idle_set", set, 2'd1);
        chk("single_idle_gnt", gnt, 3'b000);

        // Reset in the middle of a grant
        req = 3'b010; din1 = 16'h1234;
        tick();
        chk("mid_gnt", gnt, 3'b010);
        tick();
        chk("mid_bus", bus_out, 16'h1234);
        chk("mid_valid", bus_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 3'b000);
        chk("mid_rst_set", set, 2'd0);
        chk("mid_rst_bus", bus_out, 16'h0000);
        chk("mid_rst_valid", bus_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        req = 3'b001;
        tick();
        chk("post_rst_gnt", gnt, 3'b001);
        chk("post_rst_set", set, 2'd0);
        req = 3'b000;
        tick(); tick();

        // Round robin from a fresh reset: order 0,1,2,0 with one GAP cycle each
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            ow = (k == 3) ? 2'd0 : 2'(k);
            oh = 3'(3'b001 << ow);
            tick();
            chk("rr_gnt", gnt, oh);
            chk("rr_set", set, ow);
            tick();
            chk("rr_gnt2", gnt, oh);
            chk("rr_valid", bus_valid, 1'b1);
            req = 3'b111 & ~oh;
            tick();
            chk("rr_exit_gnt", gnt, 3'b000);
            chk("rr_gap_busy", busy, 1'b1);
            req = 3'b111;
            tick();
            chk("rr_idle_gnt", gnt, 3'b000);
            chk("rr_idle_busy", busy, 1'b0);
        end
        req = 3'b000;
        tick();

        // Preemption: owner 0 held, requester 2 raised in grant cycle 3
        req = 3'b001; din0 = 16'd1;
        tick();
        chk("pre_gnt1", gnt, 3'b001);
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk("pre_gnt", gnt, 3'b001);
            chk("pre_bus", bus_out, 32'(c - 1));
            din0 = 16'(c);
            if (c == 3) req = 3'b101;
        end
        tick();
        chk("pre_exit_gnt", gnt, 3'b000);
        chk("pre_exit_valid", bus_valid, 1'b0);
        chk("pre_exit_bus", bus_out, 16'd7);
        chk("pre_gap_busy", busy, 1'b1);
        tick();
        chk("pre_idle_gnt", gnt, 3'b000);
        tick();
        chk("pre_new_gnt", gnt, 3'b100);
        chk("pre_new_set", set, 2'd2);
        req = 3'b000;
        tick(); tick();

        // Lone requester 0 holds the bus for 20 cycles
        req = 3'b001;
        tick();
        chk("lone_gnt1", gnt, 3'b001);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("lone_gnt", gnt, 3'b001);
        end
        chk("lone_hold_sat", dut.r_hold_cnt, 8'd8);
        chk("lone_valid", bus_valid, 1'b1);
        req = 3'b000;
        tick(); tick();

        // Owner 0 drops exactly on its timeout cycle with requester 1 pending
        req = 3'b001;
        tick();
        chk("sim_gnt1", gnt, 3'b001);
        req = 3'b011;
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk("sim_gnt", gnt, 3'b001);
        end
        chk("sim_valid8", bus_valid, 1'b1);
        req = 3'b010;
        tick();
        chk("sim_exit_gnt", gnt, 3'b000);
        chk("sim_exit_valid", bus_valid, 1'b0);
        chk("sim_gap_busy", busy, 1'b1);
        tick();
        chk("sim_idle_gnt", gnt, 3'b000);
        tick();
        chk("sim_new_gnt", gnt, 3'b010);
        chk("sim_new_set", set, 2'd1);
        req = 3'b000;
        tick(); tick();

        // A request that rises and falls between edges is never seen
        req = 3'b100;
        #3;
        req = 3'b000;
        tick();
        chk("glitch_gnt", gnt, 3'b000);
        chk("glitch_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
